// File: rtl/csi_rx_hdr_ecc_chk.sv
// CSI-2 packet header ECC checker: single-error correction, double-error detection, saturating error counters.
// Define CSI_RX_VCX_EN to extend ECC coverage to the VCX bits in_hdr[31:30].
`timescale 1ns/1ps
module csi_rx_hdr_ecc_chk #(
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_hdr,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [23:0]      out_hdr,
    output logic [1:0]       out_vcx,
    output logic             out_corr,
    output logic             out_fatal,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_fatal
);

`ifdef CSI_RX_VCX_EN
    localparam int NB = 26;
`else
    localparam int NB = 24;
`endif
    localparam logic [1:0] VCX_MASK = (NB > 24) ? 2'b11 : 2'b00;

    typedef struct packed {
        logic [25:0] data;
        logic        corr;
        logic        fatal;
    } fix_t;

    // Hamming column of each covered bit; 24/25 are the VCX bits in_hdr[30]/[31].
    function automatic logic [5:0] col(input int i);
        case (i)
            0:  col = 6'h07;  1:  col = 6'h0B;  2:  col = 6'h0D;  3:  col = 6'h0E;
            4:  col = 6'h13;  5:  col = 6'h15;  6:  col = 6'h16;  7:  col = 6'h19;
            8:  col = 6'h1A;  9:  col = 6'h1C;  10: col = 6'h23;  11: col = 6'h25;
            12: col = 6'h26;  13: col = 6'h29;  14: col = 6'h2A;  15: col = 6'h2C;
            16: col = 6'h31;  17: col = 6'h32;  18: col = 6'h34;  19: col = 6'h38;
            20: col = 6'h1F;  21: col = 6'h2F;  22: col = 6'h37;  23: col = 6'h3B;
            24: col = 6'h3D;  25: col = 6'h3E;
            default: col = 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] calc_syn(input logic [25:0] d, input logic [5:0] ecc);
        logic [5:0] acc;
        acc = 6'h00;
        for (int i = 0; i < NB; i++)
            if (d[i]) acc = acc ^ col(i);
        calc_syn = acc ^ ecc;
    endfunction

    function automatic fix_t fix(input logic [25:0] d, input logic [5:0] syn);
        fix_t r;
        logic hit;
        hit    = 1'b0;
        r.data = d;
        for (int i = 0; i < NB; i++) begin
            if (syn == col(i)) begin
                r.data[i] = ~d[i];
                hit       = 1'b1;
            end
        end
        r.corr  = (syn != 6'h00) && (hit || $onehot(syn));
        r.fatal = (syn != 6'h00) && !r.corr;
        fix = r;
    endfunction

    logic [25:0] in_data;
    logic        fix_valid;
    fix_t        res;

    assign in_data = {in_hdr[31:30], in_hdr[23:0]};

    generate
        if (PIPE == 2) begin : g_pipe2
            logic        s1_valid;
            logic [25:0] s1_data;
            logic [5:0]  s1_syn;

            // Stage 1 registers the syndrome so stage 2 only has the column match to do.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_syn   <= '0;
                end else begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_data <= in_data;
                        s1_syn  <= calc_syn(in_data, in_hdr[29:24]);
                    end
                end
            end

            assign fix_valid = s1_valid;
            assign res       = fix(s1_data, s1_syn);
        end else begin : g_pipe1
            assign fix_valid = in_valid;
            assign res       = fix(in_data, calc_syn(in_data, in_hdr[29:24]));
        end
    endgenerate

    // Output fields only load on a valid result so they hold between headers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_hdr   <= '0;
            out_vcx   <= '0;
            out_corr  <= 1'b0;
            out_fatal <= 1'b0;
        end else begin
            out_valid <= fix_valid;
            if (fix_valid) begin
                out_hdr   <= res.data[23:0];
                out_vcx   <= res.data[25:24] & VCX_MASK;
                out_corr  <= res.corr;
                out_fatal <= res.fatal;
            end
        end
    end

    // Counters advance on the same edge that presents the event, so they agree with out_* that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr  <= '0;
            cnt_fatal <= '0;
        end else if (cnt_clr) begin
            cnt_corr  <= '0;
            cnt_fatal <= '0;
        end else begin
            if (fix_valid && res.corr && (cnt_corr != '1))
                cnt_corr <= cnt_corr + CNT_W'(1);
            if (fix_valid && res.fatal && (cnt_fatal != '1))
                cnt_fatal <= cnt_fatal + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_csi_rx_hdr_ecc_chk.sv
// Directed self-checking bench for csi_rx_hdr_ecc_chk (PIPE=2, CNT_W=4, default build without CSI_RX_VCX_EN).
`timescale 1ns/1ps
module tb_csi_rx_hdr_ecc_chk;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_hdr;
    logic        cnt_clr;
    logic        out_valid;
    logic [23:0] out_hdr;
    logic [1:0]  out_vcx;
    logic        out_corr;
    logic        out_fatal;
    logic [3:0]  cnt_corr;
    logic [3:0]  cnt_fatal;

    int compared   = 0;
    int mismatched = 0;

    // Hand-computed: ECC of 24'h001234 is 0x31 (columns of bits 2,4,5,9,12).
    localparam logic [31:0] HDR_CLEAN  = 32'h3100_1234;
    localparam logic [31:0] HDR_D23    = 32'h3180_1234;
    localparam logic [31:0] HDR_E26    = 32'h3500_1234;
    localparam logic [31:0] HDR_DBL    = 32'h3100_1237;
    localparam logic [31:0] HDR_VCX    = 32'hF100_1234;
    localparam logic [31:0] HDR_SYN3F  = 32'h0E00_1234;
    localparam logic [31:0] HDR_D0     = 32'h3100_1235;

    csi_rx_hdr_ecc_chk #(.PIPE(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_hdr    (in_hdr),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .out_hdr   (out_hdr),
        .out_vcx   (out_vcx),
        .out_corr  (out_corr),
        .out_fatal (out_fatal),
        .cnt_corr  (cnt_corr),
        .cnt_fatal (cnt_fatal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [23:0] hdr, input logic [1:0] vcx,
                             input logic corr, input logic fatal, input logic [3:0] cc, input logic [3:0] cf);
        check_output({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_output({tag, ".hdr"},   32'(out_hdr),   32'(hdr));
        check_output({tag, ".vcx"},   32'(out_vcx),   32'(vcx));
        check_output({tag, ".corr"},  32'(out_corr),  32'(corr));
        check_output({tag, ".fatal"}, 32'(out_fatal), 32'(fatal));
        check_output({tag, ".ccorr"}, 32'(cnt_corr),  32'(cc));
        check_output({tag, ".cfatal"},32'(cnt_fatal), 32'(cf));
    endtask

    // One header in, then wait out the two-cycle latency; clr is held across both edges.
    task automatic apply_stimulus(input logic [31:0] hdr, input logic clr);
        in_valid = 1'b1;
        in_hdr   = hdr;
        cnt_clr  = clr;
        tick();
        in_valid = 1'b0;
        in_hdr   = '0;
        tick();
        cnt_clr  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_hdr   = '0;
        cnt_clr  = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 24'h0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        tick();

        apply_stimulus(HDR_CLEAN, 1'b0);
        check_all("clean", 1'b1, 24'h001234, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);

        apply_stimulus(HDR_D23, 1'b0);
        check_all("data_bit23", 1'b1, 24'h001234, 2'b00, 1'b1, 1'b0, 4'd1, 4'd0);

        apply_stimulus(HDR_E26, 1'b0);
        check_all("ecc_bit26", 1'b1, 24'h001234, 2'b00, 1'b1, 1'b0, 4'd2, 4'd0);

        apply_stimulus(HDR_DBL, 1'b0);
        check_all("double", 1'b1, 24'h001237, 2'b00, 1'b0, 1'b1, 4'd2, 4'd1);

        tick();
        check_all("hold", 1'b0, 24'h001237, 2'b00, 1'b0, 1'b1, 4'd2, 4'd1);

        apply_stimulus(HDR_VCX, 1'b0);
        check_all("vcx_ignored", 1'b1, 24'h001234, 2'b00, 1'b0, 1'b0, 4'd2, 4'd1);

        apply_stimulus(HDR_SYN3F, 1'b0);
        check_all("syn3f", 1'b1, 24'h001234, 2'b00, 1'b0, 1'b1, 4'd2, 4'd2);

        in_valid = 1'b1;
        in_hdr   = HDR_D0;
        tick();
        in_hdr   = HDR_CLEAN;
        tick();
        in_valid = 1'b0;
        in_hdr   = '0;
        check_all("b2b_first", 1'b1, 24'h001234, 2'b00, 1'b1, 1'b0, 4'd3, 4'd2);
        tick();
        check_all("b2b_second", 1'b1, 24'h001234, 2'b00, 1'b0, 1'b0, 4'd3, 4'd2);
        tick();
        check_output("b2b_idle.valid", 32'(out_valid), 32'd0);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("clr.ccorr",  32'(cnt_corr),  32'd0);
        check_output("clr.cfatal", 32'(cnt_fatal), 32'd0);

        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_hdr   = HDR_DBL;
            tick();
        end
        in_valid = 1'b0;
        in_hdr   = '0;
        tick();
        check_output("sat.cfatal", 32'(cnt_fatal), 32'd15);
        check_output("sat.ccorr",  32'(cnt_corr),  32'd0);

        apply_stimulus(HDR_DBL, 1'b1);
        check_all("clr_prio", 1'b1, 24'h001237, 2'b00, 1'b0, 1'b1, 4'd0, 4'd0);

        in_valid = 1'b1;
        in_hdr   = HDR_D23;
        tick();
        in_valid = 1'b0;
        in_hdr   = '0;
        rst      = 1'b1;
        #1;
        check_all("rst_async", 1'b0, 24'h0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        check_all("rst_flush1", 1'b0, 24'h0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        check_all("rst_flush2", 1'b0, 24'h0, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);

        apply_stimulus(HDR_CLEAN, 1'b0);
        check_all("post_rst", 1'b1, 24'h001234, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/csi_rx_hdr_ecc_chk.md
CSI_RX_HDR_ECC_CHK -- requirements
Module: csi_rx_hdr_ecc_chk

Interface
REQ-001 SHALL have parameter PIPE, default 2, meaning input-to-output latency in cycles (legal values 1 or 2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each error counter (legal 4..32).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_hdr carries a packet header this cycle.
REQ-006 SHALL have port in_hdr  input  32  received header: [23:0] DI+WC, [29:24] ECC, [31:30] VCX/reserved.
REQ-007 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-008 SHALL have port out_valid  output  1  out_* fields valid this cycle.
REQ-009 SHALL have port out_hdr  output  24  corrected DI+WC.
REQ-010 SHALL have port out_vcx  output  2  corrected VCX bits (zero when CSI_RX_VCX_EN is absent).
REQ-011 SHALL have port out_corr  output  1  single-bit error found and corrected.
REQ-012 SHALL have port out_fatal  output  1  uncorrectable error; header unusable.
REQ-013 SHALL have ports cnt_corr and cnt_fatal  output  CNT_W each  saturating event counters.

Function
REQ-014 SHALL compute expected 6-bit ECC over covered bits with the CSI-2 Hamming columns (e.g. bit0 -> 0x07, bit20 -> 0x1F, bit23 -> 0x3B); syndrome = expected XOR in_hdr[29:24].
REQ-015 SHALL treat syndrome 0 as clean: out_hdr = in_hdr[23:0], out_corr = 0, out_fatal = 0.
REQ-016 SHALL, when syndrome equals the column of exactly one covered data bit, invert that bit in the output and assert out_corr.
REQ-017 SHALL, when syndrome has exactly one bit set, pass data unchanged and assert out_corr (error in ECC byte).
REQ-018 SHALL, for any other non-zero syndrome, pass data unchanged and assert out_fatal; out_corr and out_fatal are never both 1.
REQ-019 SHALL produce outputs exactly PIPE cycles after the in_valid cycle; PIPE=2 registers syndrome in stage 1 and correction in stage 2; PIPE=1 does both in one registered stage.
REQ-020 SHALL accept a new header every cycle with no backpressure; back-to-back headers emerge back-to-back in order.
REQ-021 SHALL hold out_hdr, out_vcx, out_corr, out_fatal at their last values while out_valid = 0; out_corr/out_fatal are qualified only by out_valid.
REQ-022 SHALL increment cnt_corr on each out_valid with out_corr, cnt_fatal on each out_valid with out_fatal, saturating at all-ones without wrap.
REQ-023 SHALL give cnt_clr priority: a cycle with cnt_clr and a counting event yields counter value 0.

Reset
REQ-024 SHALL, on rst assertion, immediately force out_valid, out_corr, out_fatal, out_hdr, out_vcx, cnt_corr, cnt_fatal and all pipeline state to 0.
REQ-025 SHALL discard headers in flight at reset; the first out_valid after release follows the first post-reset in_valid by PIPE cycles.

Configuration
REQ-026 SHALL, with macro CSI_RX_VCX_EN defined, cover 26 bits: in_hdr[30] with column 0x3D and in_hdr[31] with column 0x3E, correctable like data bits, out_vcx = corrected in_hdr[31:30].
REQ-027 SHALL, without CSI_RX_VCX_EN, cover 24 bits only, ignore in_hdr[31:30], and drive out_vcx = 0.

Verification
REQ-028 SHALL verify clean header: in_hdr = {2'b00, correct ECC, 24'h00_1234} -> PIPE cycles later out_hdr = 24'h001234, out_corr = 0, out_fatal = 0.
REQ-029 SHALL verify data-bit correction: same header with bit 23 flipped -> out_hdr = 24'h001234, out_corr = 1, cnt_corr = 1.
REQ-030 SHALL verify ECC-bit error: correct header with in_hdr[26] flipped -> out_hdr unchanged, out_corr = 1, out_fatal = 0.
REQ-031 SHALL verify double error: bits 0 and 1 flipped (syndrome 0x07^0x0B = 0x0C) -> out_fatal = 1, out_hdr = received bits, cnt_fatal = 1.
REQ-032 SHALL verify saturation and clear: CNT_W = 4, 17 fatal headers -> cnt_fatal = 15; cnt_clr coincident with 18th -> cnt_fatal = 0.
REQ-033 SHALL verify reset mid-stream: PIPE = 2, rst asserted one cycle after in_valid -> no out_valid emerges; all outputs 0.
